// File: rtl/cache_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_regs
// Description : Avalon-MM control/status registers of the unified cache:
//               enable, IO address windows and maintenance command handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_regs #(
  parameter int ADDR_BLOCK_NUM = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteEnable,
  input  logic        s0_read,
  output logic [31:0] s0_readData,
  input  logic        s0_write,
  input  logic [31:0] s0_writeData,
  output logic        s0_waitRequest,
  output logic        s0_readDataValid,
  input  logic [31:0] address,
  output logic        isIOAddrBlock,
  output logic        isEnableCache,
  output logic [2:0]  cmd,
  input  logic        cmd_ready
);

  localparam logic [5:0] c_IDX_CTRL = 6'd0;
  localparam logic [5:0] c_IDX_CMD  = 6'd1;

  logic                      r_ctrlEn;
  logic [ADDR_BLOCK_NUM-1:0] r_winEn;
  logic [31:0]               r_base [ADDR_BLOCK_NUM];
  logic [31:0]               r_mask [ADDR_BLOCK_NUM];
  logic [2:0]                r_cmd;
  logic [31:0]               r_readData;
  logic                      r_readDataValid;

  logic [5:0]                w_wordIdx;
  logic                      w_cmdAccess;
  logic                      w_wrAccept;
  logic                      w_rdAccept;
  logic                      w_cmdValid;
  logic [31:0]               w_rdData;
  logic [ADDR_BLOCK_NUM-1:0] w_winHit;
  logic                      w_unusedAddrBits;

  function automatic logic [31:0] f_merge(input logic [31:0] oldVal,
                                          input logic [31:0] newVal,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = newVal[8*b +: 8];
    end
    return res;
  endfunction

  assign w_wordIdx        = s0_address[7:2];
  assign w_unusedAddrBits = ^{s0_address[31:8], s0_address[1:0]};

  // A new command may only be written once the previous one has been taken.
  assign w_cmdAccess    = s0_write && (w_wordIdx == c_IDX_CMD) && s0_byteEnable[0];
  assign s0_waitRequest = w_cmdAccess && (r_cmd != 3'd0);
  assign w_wrAccept     = s0_write && !s0_waitRequest;
  assign w_rdAccept     = s0_read && !s0_write;
  assign w_cmdValid     = (s0_writeData[2:0] == 3'd1) || (s0_writeData[2:0] == 3'd2) ||
                          (s0_writeData[2:0] == 3'd3);

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_ctrlEn <= 1'b0;
      r_winEn  <= '0;
      for (int i = 0; i < ADDR_BLOCK_NUM; i++) begin
        r_base[i] <= '0;
        r_mask[i] <= '0;
      end
    end else if (w_wrAccept) begin
      if (w_wordIdx == c_IDX_CTRL) begin
        if (s0_byteEnable[0]) r_ctrlEn <= s0_writeData[0];
        if (s0_byteEnable[1]) r_winEn  <= s0_writeData[8 +: ADDR_BLOCK_NUM];
      end
      for (int i = 0; i < ADDR_BLOCK_NUM; i++) begin
        if (w_wordIdx == 6'(4 + 2*i)) r_base[i] <= f_merge(r_base[i], s0_writeData, s0_byteEnable);
        if (w_wordIdx == 6'(5 + 2*i)) r_mask[i] <= f_merge(r_mask[i], s0_writeData, s0_byteEnable);
      end
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_cmd <= 3'd0;
    end else if (r_cmd != 3'd0) begin
      if (cmd_ready) r_cmd <= 3'd0;
    end else if (w_wrAccept && w_cmdAccess && w_cmdValid) begin
      r_cmd <= s0_writeData[2:0];
    end
  end

  always_comb begin
    w_rdData = '0;
    if (w_wordIdx == c_IDX_CTRL) begin
      w_rdData[0]                   = r_ctrlEn;
      w_rdData[8 +: ADDR_BLOCK_NUM] = r_winEn;
    end
    if (w_wordIdx == c_IDX_CMD) begin
      w_rdData = {(r_cmd != 3'd0), 28'd0, r_cmd};
    end
    for (int i = 0; i < ADDR_BLOCK_NUM; i++) begin
      if (w_wordIdx == 6'(4 + 2*i)) w_rdData = r_base[i];
      if (w_wordIdx == 6'(5 + 2*i)) w_rdData = r_mask[i];
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_readData      <= '0;
      r_readDataValid <= 1'b0;
    end else begin
      r_readDataValid <= w_rdAccept;
      if (w_rdAccept) r_readData <= w_rdData;
    end
  end

  always_comb begin
    w_winHit = '0;
    for (int i = 0; i < ADDR_BLOCK_NUM; i++) begin
      w_winHit[i] = r_winEn[i] && ((address & r_mask[i]) == (r_base[i] & r_mask[i]));
    end
  end

  assign isIOAddrBlock    = |w_winHit;
  assign isEnableCache    = r_ctrlEn;
  assign cmd              = r_cmd;
  assign s0_readData      = r_readData;
  assign s0_readDataValid = r_readDataValid;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_regs
// Description : Self-checking bench: register vector table plus command
//               handshake, wait-state and reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_regs;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] s0_address;
  logic [3:0]  s0_byteEnable;
  logic        s0_read;
  logic [31:0] s0_readData;
  logic        s0_write;
  logic [31:0] s0_writeData;
  logic        s0_waitRequest;
  logic        s0_readDataValid;
  logic [31:0] address;
  logic        isIOAddrBlock;
  logic        isEnableCache;
  logic [2:0]  cmd;
  logic        cmd_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] ioAddr;
    bit          expRdV;
    logic [31:0] expRd;
    bit          expEn;
    bit          expIo;
    logic [2:0]  expCmd;
  } vec_t;

  localparam int c_NVEC = 21;
  vec_t vecs [c_NVEC];

  cache_ctrl_regs #(.ADDR_BLOCK_NUM(4)) dut (
    .clk              (clk),
    .rest             (rest),
    .s0_address       (s0_address),
    .s0_byteEnable    (s0_byteEnable),
    .s0_read          (s0_read),
    .s0_readData      (s0_readData),
    .s0_write         (s0_write),
    .s0_writeData     (s0_writeData),
    .s0_waitRequest   (s0_waitRequest),
    .s0_readDataValid (s0_readDataValid),
    .address          (address),
    .isIOAddrBlock    (isIOAddrBlock),
    .isEnableCache    (isEnableCache),
    .cmd              (cmd),
    .cmd_ready        (cmd_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic busCycle(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    s0_write      = wr;
    s0_read       = rd;
    s0_address    = a;
    s0_writeData  = d;
    s0_byteEnable = be;
    @(posedge clk);
    #1;
    s0_write = 1'b0;
    s0_read  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //            wr rd addr          wdata          be     ioAddr        rdV rdData        en io cmd
    vecs[0]  = '{0, 1, 32'h00, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h0,          0, 0, 3'd0};
    vecs[1]  = '{0, 1, 32'h04, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h0,          0, 0, 3'd0};
    vecs[2]  = '{0, 1, 32'h10, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h0,          0, 0, 3'd0};
    vecs[3]  = '{1, 0, 32'h10, 32'h8000_0000,  4'hF, 32'h8000_0010, 0, 32'h0,          0, 0, 3'd0};
    vecs[4]  = '{1, 0, 32'h14, 32'hF000_0000,  4'hF, 32'h8000_0010, 0, 32'h0,          0, 0, 3'd0};
    vecs[5]  = '{1, 0, 32'h00, 32'h0000_0101,  4'hF, 32'h8000_0010, 0, 32'h0,          1, 1, 3'd0};
    vecs[6]  = '{0, 1, 32'h00, 32'h0,          4'hF, 32'h0000_0010, 1, 32'h0000_0101,  1, 0, 3'd0};
    vecs[7]  = '{0, 1, 32'h14, 32'h0,          4'hF, 32'h8000_0010, 1, 32'hF000_0000,  1, 1, 3'd0};
    vecs[8]  = '{1, 0, 32'h00, 32'h0000_0001,  4'hF, 32'h8000_0010, 0, 32'h0,          1, 0, 3'd0};
    vecs[9]  = '{1, 0, 32'h18, 32'hAABB_CCDD,  4'h5, 32'h8000_0010, 0, 32'h0,          1, 0, 3'd0};
    vecs[10] = '{0, 1, 32'h18, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h00BB_00DD,  1, 0, 3'd0};
    vecs[11] = '{1, 0, 32'h04, 32'h0000_0005,  4'hF, 32'h8000_0010, 0, 32'h0,          1, 0, 3'd0};
    vecs[12] = '{0, 1, 32'h04, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h0,          1, 0, 3'd0};
    vecs[13] = '{1, 0, 32'h30, 32'hFFFF_FFFF,  4'hF, 32'h8000_0010, 0, 32'h0,          1, 0, 3'd0};
    vecs[14] = '{0, 1, 32'h30, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h0,          1, 0, 3'd0};
    vecs[15] = '{0, 1, 32'h08, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h0,          1, 0, 3'd0};
    vecs[16] = '{1, 1, 32'h00, 32'h0000_0101,  4'hF, 32'h8000_0010, 0, 32'h0,          1, 1, 3'd0};
    // Windows 1..3 have MASK=0, so enabling them matches every address.
    vecs[17] = '{1, 0, 32'h00, 32'h0000_0F00,  4'h2, 32'h0000_0010, 0, 32'h0,          1, 1, 3'd0};
    vecs[18] = '{0, 1, 32'h00, 32'h0,          4'hF, 32'h0000_0010, 1, 32'h0000_0F01,  1, 1, 3'd0};
    vecs[19] = '{1, 0, 32'h00, 32'h0000_0000,  4'hF, 32'h8000_0010, 0, 32'h0,          0, 0, 3'd0};
    vecs[20] = '{0, 1, 32'h2C, 32'h0,          4'hF, 32'h8000_0010, 1, 32'h0,          0, 0, 3'd0};

    rest          = 1'b1;
    s0_address    = '0;
    s0_byteEnable = '0;
    s0_read       = 1'b0;
    s0_write      = 1'b0;
    s0_writeData  = '0;
    address       = 32'h8000_0010;
    cmd_ready     = 1'b0;
    idle(3);
    rest = 1'b0;

    check("reset readData",      s0_readData, 32'h0);
    check("reset readDataValid", 32'(s0_readDataValid), 32'h0);
    check("reset waitRequest",   32'(s0_waitRequest), 32'h0);
    check("reset isEnableCache", 32'(isEnableCache), 32'h0);
    check("reset isIOAddrBlock", 32'(isIOAddrBlock), 32'h0);
    check("reset cmd",           32'(cmd), 32'h0);

    for (int i = 0; i < c_NVEC; i++) begin
      address = vecs[i].ioAddr;
      busCycle(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      check($sformatf("vec%0d readDataValid", i), 32'(s0_readDataValid), 32'(vecs[i].expRdV));
      if (vecs[i].expRdV) check($sformatf("vec%0d readData", i), s0_readData, vecs[i].expRd);
      check($sformatf("vec%0d isEnableCache", i), 32'(isEnableCache), 32'(vecs[i].expEn));
      check($sformatf("vec%0d isIOAddrBlock", i), 32'(isIOAddrBlock), 32'(vecs[i].expIo));
      check($sformatf("vec%0d cmd", i), 32'(cmd), 32'(vecs[i].expCmd));
    end

    // Command 3 held until cmd_ready, readable with busy bit.
    busCycle(1, 0, 32'h04, 32'h3, 4'h1);
    check("cmd3 loaded", 32'(cmd), 32'd3);
    idle(2);
    check("cmd3 held", 32'(cmd), 32'd3);
    busCycle(0, 1, 32'h04, 32'h0, 4'hF);
    check("cmd3 read valid", 32'(s0_readDataValid), 32'h1);
    check("cmd3 read data", s0_readData, 32'h8000_0003);
    cmd_ready = 1'b1;
    idle(1);
    cmd_ready = 1'b0;
    check("cmd3 cleared", 32'(cmd), 32'd0);

    // Second command stalls until the pending one is taken.
    busCycle(1, 0, 32'h04, 32'h1, 4'hF);
    check("cmd1 loaded", 32'(cmd), 32'd1);
    s0_write      = 1'b1;
    s0_address    = 32'h04;
    s0_writeData  = 32'h2;
    s0_byteEnable = 4'hF;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall waitRequest %0d", k), 32'(s0_waitRequest), 32'h1);
      check($sformatf("stall cmd %0d", k), 32'(cmd), 32'd1);
      @(posedge clk);
      #2;
    end
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    #1;
    check("released cmd", 32'(cmd), 32'd0);
    check("released waitRequest", 32'(s0_waitRequest), 32'h0);
    @(posedge clk);
    #1;
    s0_write = 1'b0;
    check("cmd2 accepted", 32'(cmd), 32'd2);
    cmd_ready = 1'b1;
    idle(1);
    cmd_ready = 1'b0;
    check("cmd2 cleared", 32'(cmd), 32'd0);

    // cmd_ready high while idle is ignored; minimum lifetime of one cycle.
    cmd_ready = 1'b1;
    busCycle(1, 0, 32'h04, 32'h2, 4'h1);
    check("minlife loaded", 32'(cmd), 32'd2);
    idle(1);
    cmd_ready = 1'b0;
    check("minlife cleared", 32'(cmd), 32'd0);

    // CMD write without byte lane 0 is ignored.
    busCycle(1, 0, 32'h04, 32'h1, 4'hE);
    check("cmd lane0 off", 32'(cmd), 32'd0);

    // Asynchronous reset mid-command.
    busCycle(1, 0, 32'h00, 32'h1, 4'hF);
    busCycle(1, 0, 32'h04, 32'h1, 4'hF);
    check("pre-reset cmd", 32'(cmd), 32'd1);
    check("pre-reset enable", 32'(isEnableCache), 32'h1);
    #2;
    rest = 1'b1;
    #1;
    check("async reset cmd", 32'(cmd), 32'd0);
    check("async reset enable", 32'(isEnableCache), 32'h0);
    @(posedge clk);
    #1;
    rest = 1'b0;
    idle(1);
    check("post-reset cmd", 32'(cmd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
